// File: rtl/edulent_sequencer.sv
// Control sequencer for the Edulent 8-bit CPU: fetch/decode/execute FSM with a
// memory req/ready handshake, stack bookkeeping, traps and a retired-instruction counter.
module edulent_sequencer #(
   parameter int unsigned STACK_DEPTH  = 16,
   parameter int unsigned WAIT_TIMEOUT = 15,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                             i_clk,
   input  logic                             i_rstn,
   input  logic [7:0]                       i_opcode,
   input  logic                             i_mem_ready,
   output logic [3:0]                       o_transfer_cmd,
   output logic                             o_dst_ap,
   output logic [2:0]                       o_alu_cmd,
   output logic                             o_inc_pc,
   output logic [1:0]                       o_inc_dec_sp,
   output logic                             o_mem_req,
   output logic                             o_mem_we,
   output logic                             o_instr_done,
   output logic [CNT_W-1:0]                 o_instr_count,
   output logic [$clog2(STACK_DEPTH+1)-1:0] o_stack_level,
   output logic                             o_halted,
   output logic                             o_fault,
   output logic [2:0]                       o_fault_code
);

   localparam int unsigned LVL_W  = $clog2(STACK_DEPTH + 1);
   localparam int unsigned WAIT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

   localparam logic [3:0] CMD_NONE   = 4'h0, CMD_MA_PC  = 4'h1, CMD_MD_MEM = 4'h2,
                          CMD_IR_MD  = 4'h3, CMD_MA_MD  = 4'h4, CMD_REG_MD = 4'h5,
                          CMD_MA_AP  = 4'h6, CMD_MA_SP  = 4'h7, CMD_MD_REG = 4'h8,
                          CMD_MEM_MD = 4'h9, CMD_REG_R  = 4'hA, CMD_PC_MD  = 4'hB,
                          CMD_A_IN   = 4'hC, CMD_OUT_A  = 4'hD, CMD_PC_AP  = 4'hE,
                          CMD_MD_PC  = 4'hF;
   localparam logic [1:0] SP_HOLD = 2'b00, SP_POP = 2'b01, SP_PUSH = 2'b10;

   typedef enum logic [4:0] {
      RESET, FETCH_ADDR, FETCH_WAIT, DECODE, DISPATCH, OPR_ADDR, OPR_WAIT,
      MEM_WAIT, MEM_WRITE, LD, ALU, WB, MA_MD, MA_AP, MD_REG, JMP, DEC_SP,
      MA_SP, AP_LD, MD_PC, PC_AP, IN_ST, OUT_ST, DONE, HALTED, FAULT
   } state_e;

   typedef enum logic [4:0] {
      K_NOP, K_LDI, K_ALUI, K_LDM, K_LDA, K_ALUA, K_ALUR, K_ST, K_JMP,
      K_PUSH, K_POP, K_CALL, K_RET, K_IN, K_OUT, K_HALT, K_ILL
   } kind_e;

   // Instruction class selects the micro-sequence taken after DISPATCH.
   function automatic kind_e decode_kind(input logic [7:0] op);
      kind_e k;
      case (op)
         8'h00:                                          k = K_NOP;
         8'h19, 8'h1B:                                   k = K_LDI;
         8'h39, 8'h49, 8'h69, 8'h79, 8'h89, 8'h3B, 8'h4B: k = K_ALUI;
         8'h11, 8'h13:                                   k = K_LDM;
         8'h14:                                          k = K_LDA;
         8'h34, 8'h44, 8'h64, 8'h74, 8'h84:              k = K_ALUA;
         8'h50, 8'h90:                                   k = K_ALUR;
         8'h21, 8'h23:                                   k = K_ST;
         8'hA1:                                          k = K_JMP;
         8'h2C, 8'h2E:                                   k = K_PUSH;
         8'h1C, 8'h1E:                                   k = K_POP;
         8'hC1:                                          k = K_CALL;
         8'hB0:                                          k = K_RET;
         8'hD0:                                          k = K_IN;
         8'hE0:                                          k = K_OUT;
         8'hF0:                                          k = K_HALT;
         default:                                        k = K_ILL;
      endcase
      return k;
   endfunction

   function automatic logic [2:0] alu_map(input logic [3:0] hi);
      logic [2:0] a;
      case (hi)
         4'h3:    a = 3'b001;
         4'h4:    a = 3'b010;
         4'h6:    a = 3'b011;
         4'h7:    a = 3'b100;
         4'h8:    a = 3'b101;
         4'h5:    a = 3'b110;
         4'h9:    a = 3'b111;
         default: a = 3'b000;
      endcase
      return a;
   endfunction

   state_e            state, next_state;
   kind_e             kind_q, disp_kind;
   logic              ap_q;
   logic [2:0]        alu_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic [LVL_W-1:0]  level;
   logic [CNT_W-1:0]  count;
   logic [2:0]        fault_code;

   logic [3:0] cmd;
   logic       mem_req, mem_we, inc_pc, dst_ap, done, in_wait;
   logic [1:0] sp_op;
   logic [2:0] alu, set_code;
   logic       stack_full, stack_empty, timeout_hit;

   assign disp_kind   = decode_kind(i_opcode);
   assign stack_full  = (level == LVL_W'(STACK_DEPTH));
   assign stack_empty = (level == '0);
   assign timeout_hit = (WAIT_TIMEOUT > 0) && (wait_cnt == WAIT_LAST);

   // State register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= RESET;
      else         state <= next_state;
   end

   // Next state and Moore command decode; step pulses in wait states gate on ready.
   always_comb begin
      next_state = state;
      cmd        = CMD_NONE;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      inc_pc     = 1'b0;
      sp_op      = SP_HOLD;
      alu        = 3'b000;
      dst_ap     = 1'b0;
      done       = 1'b0;
      in_wait    = 1'b0;
      set_code   = 3'd0;
      case (state)
         RESET:      next_state = FETCH_ADDR;
         FETCH_ADDR: begin cmd = CMD_MA_PC; next_state = FETCH_WAIT; end
         FETCH_WAIT: begin
            cmd = CMD_MD_MEM; mem_req = 1'b1; in_wait = 1'b1;
            if (i_mem_ready) begin inc_pc = 1'b1; next_state = DECODE; end
         end
         DECODE:     begin cmd = CMD_IR_MD; next_state = DISPATCH; end
         DISPATCH: begin
            case (disp_kind)
               K_NOP:                            next_state = DONE;
               K_LDI, K_ALUI, K_LDM, K_ST, K_JMP: next_state = OPR_ADDR;
               K_LDA, K_ALUA:                    next_state = MA_AP;
               K_ALUR:                           next_state = ALU;
               K_IN:                             next_state = IN_ST;
               K_OUT:                            next_state = OUT_ST;
               K_HALT:                           next_state = HALTED;
               K_CALL, K_PUSH: begin
                  if (stack_full) begin next_state = FAULT; set_code = 3'd2; end
                  else next_state = (disp_kind == K_CALL) ? OPR_ADDR : DEC_SP;
               end
               K_POP, K_RET: begin
                  if (stack_empty) begin next_state = FAULT; set_code = 3'd3; end
                  else next_state = MA_SP;
               end
               default: begin next_state = FAULT; set_code = 3'd1; end
            endcase
         end
         OPR_ADDR:   begin cmd = CMD_MA_PC; next_state = OPR_WAIT; end
         OPR_WAIT: begin
            cmd = CMD_MD_MEM; mem_req = 1'b1; in_wait = 1'b1;
            if (i_mem_ready) begin
               inc_pc = 1'b1;
               case (kind_q)
                  K_LDI:   next_state = LD;
                  K_ALUI:  next_state = ALU;
                  K_CALL:  next_state = AP_LD;
                  default: next_state = MA_MD;
               endcase
            end
         end
         MEM_WAIT: begin
            cmd = CMD_MD_MEM; mem_req = 1'b1; in_wait = 1'b1;
            if (i_mem_ready) begin
               if (kind_q == K_POP || kind_q == K_RET) sp_op = SP_POP;
               case (kind_q)
                  K_ALUA:       next_state = ALU;
                  K_JMP, K_RET: next_state = JMP;
                  default:      next_state = LD;
               endcase
            end
         end
         MEM_WRITE: begin
            cmd = CMD_MEM_MD; mem_req = 1'b1; mem_we = 1'b1; in_wait = 1'b1;
            if (i_mem_ready) begin
               if (kind_q == K_CALL) next_state = PC_AP;
               else begin done = 1'b1; next_state = FETCH_ADDR; end
            end
         end
         MA_MD:  begin cmd = CMD_MA_MD; next_state = (kind_q == K_ST) ? MD_REG : MEM_WAIT; end
         MA_AP:  begin cmd = CMD_MA_AP; next_state = MEM_WAIT; end
         MA_SP: begin
            cmd = CMD_MA_SP;
            case (kind_q)
               K_PUSH:  next_state = MD_REG;
               K_CALL:  next_state = MD_PC;
               default: next_state = MEM_WAIT;
            endcase
         end
         MD_REG: begin cmd = CMD_MD_REG; dst_ap = ap_q; next_state = MEM_WRITE; end
         MD_PC:  begin cmd = CMD_MD_PC; next_state = MEM_WRITE; end
         DEC_SP: begin sp_op = SP_PUSH; next_state = MA_SP; end
         AP_LD:  begin cmd = CMD_REG_MD; dst_ap = 1'b1; next_state = DEC_SP; end
         ALU:    begin alu = alu_q; next_state = WB; end
         LD:     begin cmd = CMD_REG_MD; dst_ap = ap_q; done = 1'b1; next_state = FETCH_ADDR; end
         WB:     begin cmd = CMD_REG_R;  dst_ap = ap_q; done = 1'b1; next_state = FETCH_ADDR; end
         JMP:    begin cmd = CMD_PC_MD;  done = 1'b1; next_state = FETCH_ADDR; end
         PC_AP:  begin cmd = CMD_PC_AP;  done = 1'b1; next_state = FETCH_ADDR; end
         IN_ST:  begin cmd = CMD_A_IN;   done = 1'b1; next_state = FETCH_ADDR; end
         OUT_ST: begin cmd = CMD_OUT_A;  done = 1'b1; next_state = FETCH_ADDR; end
         DONE:   begin done = 1'b1; next_state = FETCH_ADDR; end
         HALTED: next_state = HALTED;
         FAULT:  next_state = FAULT;
         default: next_state = RESET;
      endcase
      if (in_wait && !i_mem_ready && timeout_hit) begin
         next_state = FAULT;
         set_code   = 3'd4;
      end
   end

   // Instruction latch, wait timer, stack level, retire counter and fault code.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         kind_q     <= K_NOP;
         ap_q       <= 1'b0;
         alu_q      <= 3'b000;
         wait_cnt   <= '0;
         level      <= '0;
         count      <= '0;
         fault_code <= 3'd0;
      end else begin
         if (state == DISPATCH) begin
            kind_q <= disp_kind;
            ap_q   <= i_opcode[1];
            alu_q  <= alu_map(i_opcode[7:4]);
         end
         wait_cnt <= (in_wait && !i_mem_ready) ? wait_cnt + WAIT_W'(1) : '0;
         if (sp_op == SP_PUSH)     level <= level + LVL_W'(1);
         else if (sp_op == SP_POP) level <= level - LVL_W'(1);
         if (done) count <= count + CNT_W'(1);
         if (set_code != 3'd0) fault_code <= set_code;
      end
   end

   assign o_transfer_cmd = cmd;
   assign o_dst_ap       = dst_ap;
   assign o_alu_cmd      = alu;
   assign o_inc_pc       = inc_pc;
   assign o_inc_dec_sp   = sp_op;
   assign o_mem_req      = mem_req;
   assign o_mem_we       = mem_we;
   assign o_instr_done   = done;
   assign o_instr_count  = count;
   assign o_stack_level  = level;
   assign o_halted       = (state == HALTED);
   assign o_fault        = (state == FAULT);
   assign o_fault_code   = fault_code;

endmodule
